// File: rtl/universal_shift_reg.sv
// Universal shift register with parallel load, single-step and counted burst operation.
// A burst latches mode and count, then applies one step per cycle until the count is used up.
module universal_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] par_in,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] data_out,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] ModeShl = 3'b001;
  localparam logic [2:0] ModeShr = 3'b010;
  localparam logic [2:0] ModeRol = 3'b011;
  localparam logic [2:0] ModeRor = 3'b100;
  localparam logic [2:0] ModeAsr = 3'b101;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             done_q, done_d;

  // One step of the selected operation; hold and reserved codes return q unchanged.
  function automatic logic [WIDTH-1:0] apply_mode(input logic [2:0]       m,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic             sr,
                                                  input logic             sl);
    logic [WIDTH-1:0] r;
    r = q;
    case (m)
      ModeShl: r = {q[WIDTH-2:0], sr};
      ModeShr: r = {sl, q[WIDTH-1:1]};
      ModeRol: r = {q[WIDTH-2:0], q[WIDTH-1]};
      ModeRor: r = {q[0], q[WIDTH-1:1]};
      ModeAsr: r = {q[WIDTH-1], q[WIDTH-1:1]};
      default: r = q;
    endcase
    return r;
  endfunction

  // Next-state: idle priority load > start > en; a burst ignores all command inputs.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          q_d = par_in;
        end else if (start) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            mode_d  = mode;
            cnt_d   = count;
            state_d = StBurst;
          end
        end else if (en) begin
          q_d = apply_mode(mode, q_q, sin_r, sin_l);
        end
      end
      StBurst: begin
        // Serial inputs stay live during a burst; only mode and count are latched.
        q_d   = apply_mode(mode_q, q_q, sin_r, sin_l);
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      q_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    data_out = q_q;
    sout_l   = q_q[WIDTH-1];
    sout_r   = q_q[0];
    busy     = (state_q == StBurst);
    done     = done_q;
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg: the driver pushes the model's expected outputs,
// a monitor pops and compares after every clock edge and every reset assertion.
module tb_universal_shift_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   mode;
  logic         load;
  logic [W-1:0] par_in;
  logic         sin_r;
  logic         sin_l;
  logic         en;
  logic         start;
  logic [3:0]   count;
  logic [W-1:0] data_out;
  logic         sout_l;
  logic         sout_r;
  logic         busy;
  logic         done;

  universal_shift_reg #(
    .WIDTH(W),
    .CNT_W(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .load    (load),
    .par_in  (par_in),
    .sin_r   (sin_r),
    .sin_l   (sin_l),
    .en      (en),
    .start   (start),
    .count   (count),
    .data_out(data_out),
    .sout_l  (sout_l),
    .sout_r  (sout_r),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         b;
    logic         dn;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;

  // Reference model: register value plus a queue of pending burst operations.
  int unsigned mq = 0;
  int          pend[$];
  bit          mdone = 1'b0;

  function automatic int unsigned op(int m, int unsigned q, bit sr, bit sl);
    int unsigned mask = (1 << W) - 1;
    int unsigned msb = 1 << (W - 1);
    case (m)
      1: return ((q << 1) | sr) & mask;
      2: return (q >> 1) | (sl ? msb : 0);
      3: return ((q << 1) | (q >> (W - 1))) & mask;
      4: return (q >> 1) | ((q & 1) != 0 ? msb : 0);
      5: return (q >> 1) | (q & msb);
      default: return q;
    endcase
  endfunction

  function automatic void model_reset();
    mq = 0;
    pend.delete();
    mdone = 1'b0;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.d  = mq[W-1:0];
    e.b  = (pend.size() > 0);
    e.dn = mdone;
    sb.push_back(e);
  endfunction

  // Advance the model by one edge using current inputs, push the expectation, run the edge.
  task automatic tick();
    if (!reset) begin
      model_reset();
    end else if (pend.size() > 0) begin
      mq = op(pend.pop_front(), mq, sin_r, sin_l);
      mdone = (pend.size() == 0);
    end else begin
      mdone = 1'b0;
      if (load) begin
        mq = par_in;
      end else if (start) begin
        if (count == 0) mdone = 1'b1;
        else for (int i = 0; i < count; i++) pend.push_back(int'(mode));
      end else if (en) begin
        mq = op(mode, mq, sin_r, sin_l);
      end
    end
    push_exp();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset between edges; outputs must clear without a clock.
  task automatic async_reset();
    model_reset();
    push_exp();
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    load = 0; start = 0; en = 0;
  endtask

  // Monitor: compare after every clock edge and every reset assertion.
  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(posedge clk or negedge reset);
      #1;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL underflow: DUT output at %0t with no expectation queued", $time);
      end else begin
        e = sb.pop_front();
        if (data_out !== e.d || sout_l !== e.d[W-1] || sout_r !== e.d[0] ||
            busy !== e.b || done !== e.dn) begin
          miscompares++;
          $display("FAIL outputs @%0t: got data=%h sl=%b sr=%b busy=%b done=%b, want data=%h busy=%b done=%b",
                   $time, data_out, sout_l, sout_r, busy, done, e.d, e.b, e.dn);
        end
      end
    end
  end

  initial begin
    reset = 0; mode = 0; load = 0; par_in = 0; sin_r = 0; sin_l = 0;
    en = 0; start = 0; count = 0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    tick();                                   // reset state
    reset = 1;
    load = 1; par_in = 8'hA5; tick(); load = 0;

    // Single steps of every mode from 8'h81.
    for (int m = 1; m <= 5; m++) begin
      load = 1; par_in = 8'h81; tick(); load = 0;
      en = 1; mode = 3'(m); sin_r = 1; sin_l = 0; tick(); en = 0;
    end
    mode = 3'b110; en = 1; tick(); en = 0;    // reserved code holds

    // Rotate-left burst of 3 from 8'h01.
    load = 1; par_in = 8'h01; tick(); load = 0;
    start = 1; count = 3; mode = 3'b011; tick(); start = 0;
    repeat (4) tick();

    // Zero-length burst.
    start = 1; count = 0; tick(); start = 0;
    repeat (2) tick();

    // Shift-right burst of 5 with commands thrown at it mid-burst.
    load = 1; par_in = 8'h96; tick(); load = 0;
    start = 1; count = 5; mode = 3'b010; tick(); start = 0;
    sin_l = 1; tick();
    load = 1; par_in = 8'hFF; mode = 3'b101; en = 1; start = 1; count = 9; tick();
    idle_inputs(); sin_l = 0;
    repeat (4) tick();

    // Back-to-back bursts: start held high is accepted in the done cycle.
    start = 1; count = 2; mode = 3'b001; sin_r = 1; tick();
    repeat (3) tick();
    start = 0; repeat (3) tick();

    // Reset mid-burst, then a fresh load.
    load = 1; par_in = 8'hAA; tick(); load = 0;
    start = 1; count = 10; mode = 3'b001; tick(); start = 0;
    repeat (4) tick();
    async_reset();
    #1;
    tick(); tick();
    reset = 1;
    load = 1; par_in = 8'h3C; tick(); load = 0;
    tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (reset && ($urandom % 128 == 0)) begin
        async_reset();
        #1;
      end else begin
        reset = 1;
      end
      load   = ($urandom % 8 == 0);
      start  = ($urandom % 4 == 0);
      en     = $urandom % 2;
      mode   = 3'($urandom % 8);
      count  = 4'($urandom % 16);
      par_in = 8'($urandom);
      sin_r  = $urandom % 2;
      sin_l  = $urandom % 2;
      tick();
    end
    reset = 1; idle_inputs();
    repeat (20) tick();

    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
